// File: rtl/pci_target_mem.sv
// pci_target_mem: DEPTH x DATA_W target store behind a PCI-style
// FRAME/IRDY/TRDY/STOP handshake with byte enables, wait states, bursts.
// Ports: clk, rst (sync, active high), Data (inout), F (FRAME_n),
//   Address/RE/WE (address phase), BE (byte enables), IRDY (active low),
//   TRDY/STOP (active low), addressReg (burst word pointer).
// Macro PCI_MEM_WRAP_EN: defined = pointer wraps at the end of the array,
//   undefined = target disconnect-with-data at DEPTH-1.
`timescale 1ns/1ps
module pci_target_mem #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 2,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  inout  wire  [DATA_W-1:0]   Data,
  input  logic                F,
  input  logic [ADDR_W-1:0]   Address,
  input  logic                RE,
  input  logic                WE,
  input  logic [DATA_W/8-1:0] BE,
  input  logic                IRDY,
  output logic                TRDY,
  output logic                STOP,
  output logic [ADDR_W-1:0]   addressReg
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DATA, S_DISC, S_DROP
  } state_t;

  state_t              state_q, state_d;
  logic                trdy_q, trdy_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DATA_W-1:0]   rd_word;
  logic                xfer;
  logic                at_end;
  logic                addr_ok;

  assign addr_ok = {1'b0, Address} < DEPTH_W;
  assign at_end  = (addr_q == LAST);
  assign xfer    = (state_q == S_DATA) && !trdy_q && !IRDY;

  always_comb begin
    rd_word = '0;
    for (int w = 0; w < DEPTH; w++) begin
      if (addr_q == ADDR_W'(w)) rd_word = mem_q[w];
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    unique case (state_q)
      S_IDLE: begin
        if (!F) begin
          addr_d = Address;
          rd_d   = RE;
          if ((RE != WE) && addr_ok) begin
            if (WAIT_STATES > 0) begin
              state_d = S_WAIT;
              cnt_d   = 3'(WAIT_STATES - 1);
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_WAIT: begin
        if (F) begin
          state_d = S_IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DATA: begin
        if (xfer) begin
          if (!rd_q) begin
            for (int w = 0; w < DEPTH; w++) begin
              if (addr_q == ADDR_W'(w)) begin
                for (int b = 0; b < NB; b++) begin
                  if (BE[b]) mem_d[w][8*b +: 8] = Data[8*b +: 8];
                end
              end
            end
          end
          if (F) state_d = S_IDLE;
          if (at_end) begin
`ifdef PCI_MEM_WRAP_EN
            addr_d = '0;
`else
            // pointer parks on the last word; disconnect unless final
            if (!F) state_d = S_DISC;
`endif
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_DISC, S_DROP: begin
        if (F) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // first DATA cycle is a turnaround: TRDY drops one edge later
    trdy_d = !((state_q == S_DATA) && (state_d == S_DATA));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      trdy_q  <= 1'b1;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      for (int w = 0; w < DEPTH; w++) mem_q[w] <= '0;
    end else begin
      state_q <= state_d;
      trdy_q  <= trdy_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  assign TRDY       = trdy_q;
  assign addressReg = addr_q;

`ifdef PCI_MEM_WRAP_EN
  assign STOP = (state_q != S_DISC);
`else
  assign STOP = !((xfer && at_end && !F) || (state_q == S_DISC));
`endif

  assign Data = ((state_q == S_DATA) && rd_q) ? rd_word : 'z;

endmodule

// File: tb/tb_pci_target_mem.sv
// tb_pci_target_mem: directed bench for pci_target_mem.
// Instance 0: DEPTH=4, no wait states; instance 1: DEPTH=3, two wait states.
`timescale 1ns/1ps
module tb_pci_target_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  f;
  logic [1:0]  addr;
  logic        re, we, irdy;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [1:0]  drv;
  wire  [31:0] data0, data1;
  logic        trdy0, trdy1, stop0, stop1;
  logic [1:0]  areg0, areg1;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign data0 = drv[0] ? wdata : 'z;
  assign data1 = drv[1] ? wdata : 'z;

  pci_target_mem #(.DATA_W(32), .DEPTH(4), .ADDR_W(2), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .Data(data0), .F(f[0]), .Address(addr),
    .RE(re), .WE(we), .BE(be), .IRDY(irdy), .TRDY(trdy0), .STOP(stop0),
    .addressReg(areg0));

  pci_target_mem #(.DATA_W(32), .DEPTH(3), .ADDR_W(2), .WAIT_STATES(2)) u1 (
    .clk(clk), .rst(rst), .Data(data1), .F(f[1]), .Address(addr),
    .RE(re), .WE(we), .BE(be), .IRDY(irdy), .TRDY(trdy1), .STOP(stop1),
    .addressReg(areg1));

  function automatic logic trdy_of(input int i);
    return (i == 0) ? trdy0 : trdy1;
  endfunction

  function automatic logic [31:0] data_of(input int i);
    return (i == 0) ? data0 : data1;
  endfunction

  task automatic start(input int i, input logic [1:0] a,
                       input logic r, input logic w);
    @(negedge clk);
    f[i] = 1'b0; addr = a; re = r; we = w; irdy = 1'b1;
  endtask

  task automatic wait_trdy(input int i, output int lat);
    lat = 0;
    @(negedge clk);
    re = 1'b0; we = 1'b0; irdy = 1'b0;
    #1;
    while (trdy_of(i) !== 1'b0 && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    if (lat >= 20) begin
      errors++; checks++;
      $display("FAIL trdy_timeout inst%0d: no TRDY within 20 cycles", i);
    end
  endtask

  task automatic do_write(input int i, input logic [1:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output int lat);
    wdata = d; be = b;
    start(i, a, 1'b0, 1'b1);
    drv[i] = 1'b1;
    wait_trdy(i, lat);
    f[i] = 1'b1;
    @(posedge clk); #1;
    drv[i] = 1'b0; irdy = 1'b1;
  endtask

  task automatic do_read(input int i, input logic [1:0] a,
                         output logic [31:0] d);
    int lat;
    start(i, a, 1'b1, 1'b0);
    wait_trdy(i, lat);
    d = data_of(i);
    f[i] = 1'b1;
    @(posedge clk); #1;
    irdy = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; f = 2'b11; irdy = 1'b1; drv = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; f = 2'b11; addr = '0; re = 0; we = 0;
    irdy = 1'b1; be = '0; wdata = '0; drv = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (trdy0 !== 1'b1) begin
      errors++; $display("FAIL reset_trdy: got %b want 1", trdy0);
    end
    checks++;
    if (stop0 !== 1'b1) begin
      errors++; $display("FAIL reset_stop: got %b want 1", stop0);
    end
    checks++;
    if (areg0 !== 2'd0) begin
      errors++; $display("FAIL reset_areg: got %0d want 0", areg0);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    start(0, 2'd2, 1'b1, 1'b0);
    @(negedge clk);
    re = 0; irdy = 1'b0; #1;
    checks++;
    if (trdy0 !== 1'b1) begin
      errors++; $display("FAIL rd_turnaround_trdy: got %b want 1", trdy0);
    end
    @(negedge clk); #1;
    checks++;
    if (trdy0 !== 1'b0) begin
      errors++; $display("FAIL rd_trdy_low: got %b want 0", trdy0);
    end
    checks++;
    if (data0 !== 32'h0) begin
      errors++; $display("FAIL rd_data: got %h want 0", data0);
    end
    checks++;
    if (stop0 !== 1'b1) begin
      errors++; $display("FAIL rd_stop: got %b want 1", stop0);
    end
    f[0] = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (trdy0 !== 1'b1 || stop0 !== 1'b1) begin
      errors++;
      $display("FAIL rd_end: got trdy=%b stop=%b want 1 1", trdy0, stop0);
    end
    irdy = 1'b1;
  endtask

  task automatic test_wait_states();
    int lat;
    logic [31:0] d;
    do_write(1, 2'd1, 32'hA5A5A5A5, 4'hF, lat);
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL ws_latency: got %0d want 3", lat);
    end
    do_read(1, 2'd1, d);
    checks++;
    if (d !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL ws_readback: got %h want a5a5a5a5", d);
    end
  endtask

  task automatic test_invalid(input int i, input logic [1:0] a,
                              input logic r, input logic w);
    wdata = 32'h77777777; be = 4'hF;
    start(i, a, r, w);
    drv[i] = w;
    @(negedge clk);
    re = 0; we = 0; irdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (trdy_of(i) !== 1'b1 || (i == 0 ? stop0 : stop1) !== 1'b1) begin
        errors++;
        $display("FAIL drop_hs inst%0d cyc%0d: got trdy=%b want 1",
                 i, c, trdy_of(i));
      end
      @(negedge clk);
    end
    f[i] = 1'b1;
    @(posedge clk); #1;
    drv[i] = 1'b0; irdy = 1'b1;
  endtask

  task automatic test_invalid_claims();
    logic [31:0] d;
    test_invalid(0, 2'd2, 1'b1, 1'b1);
    do_read(0, 2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL drop_rewe_mem: got %h want 0", d);
    end
    test_invalid(1, 2'd3, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      do_read(1, 2'(k), d);
      checks++;
      if (d !== ((k == 1) ? 32'hA5A5A5A5 : 32'h0)) begin
        errors++; $display("FAIL drop_addr_mem[%0d]: got %h", k, d);
      end
    end
  endtask

  task automatic test_byte_enables();
    int lat;
    logic [31:0] d;
    do_write(0, 2'd0, 32'h11223344, 4'hF, lat);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL be_latency: got %0d want 1", lat);
    end
    do_write(0, 2'd0, 32'h0000FF00, 4'b0010, lat);
    do_read(0, 2'd0, d);
    checks++;
    if (d !== 32'h1122FF44) begin
      errors++; $display("FAIL be_merge: got %h want 1122ff44", d);
    end
  endtask

  task automatic test_burst();
    int lat;
    logic [31:0] d;
    logic [31:0] exp_m [4];
    apply_reset();
    wdata = 32'hB0; be = 4'hF;
    start(0, 2'd2, 1'b0, 1'b1);
    drv[0] = 1'b1;
    wait_trdy(0, lat);
    @(posedge clk); #1;
    irdy = 1'b1; wdata = 32'hDEADDEAD;
    @(posedge clk); #1;
    checks++;
    if (areg0 !== 2'd3) begin
      errors++; $display("FAIL burst_stall_ptr: got %0d want 3", areg0);
    end
    irdy = 1'b0; wdata = 32'hB1;
    @(negedge clk); #1;
`ifdef PCI_MEM_WRAP_EN
    checks++;
    if (stop0 !== 1'b1 || trdy0 !== 1'b0) begin
      errors++;
      $display("FAIL burst_wrap_hs: got stop=%b trdy=%b want 1 0",
               stop0, trdy0);
    end
    for (int k = 2; k < 6; k++) begin
      @(posedge clk); #1;
      wdata = 32'hB0 + 32'(k);
      if (k == 5) f[0] = 1'b1;
    end
    @(posedge clk); #1;
    drv[0] = 1'b0; irdy = 1'b1;
    exp_m[0] = 32'hB2; exp_m[1] = 32'hB3;
    exp_m[2] = 32'hB4; exp_m[3] = 32'hB5;
`else
    checks++;
    if (stop0 !== 1'b0 || trdy0 !== 1'b0) begin
      errors++;
      $display("FAIL burst_disc_xfer: got stop=%b trdy=%b want 0 0",
               stop0, trdy0);
    end
    @(negedge clk); #1;
    checks++;
    if (stop0 !== 1'b0 || trdy0 !== 1'b1 || areg0 !== 2'd3) begin
      errors++;
      $display("FAIL burst_disc: got stop=%b trdy=%b ptr=%0d want 0 1 3",
               stop0, trdy0, areg0);
    end
    f[0] = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (stop0 !== 1'b1) begin
      errors++; $display("FAIL burst_disc_end: got stop=%b want 1", stop0);
    end
    drv[0] = 1'b0; irdy = 1'b1;
    exp_m[0] = 32'h0; exp_m[1] = 32'h0;
    exp_m[2] = 32'hB0; exp_m[3] = 32'hB1;
`endif
    for (int k = 0; k < 4; k++) begin
      do_read(0, 2'(k), d);
      checks++;
      if (d !== exp_m[k]) begin
        errors++;
        $display("FAIL burst_mem[%0d]: got %h want %h", k, d, exp_m[k]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int lat;
    logic [31:0] d;
    wdata = 32'hCAFE0000; be = 4'hF;
    start(0, 2'd0, 1'b0, 1'b1);
    drv[0] = 1'b1;
    wait_trdy(0, lat);
    @(posedge clk); #1;
    wdata = 32'h0000BEEF; rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (trdy0 !== 1'b1) begin
      errors++; $display("FAIL rstmid_trdy: got %b want 1", trdy0);
    end
    checks++;
    if (areg0 !== 2'd0) begin
      errors++; $display("FAIL rstmid_ptr: got %0d want 0", areg0);
    end
    rst = 1'b0; f[0] = 1'b1; drv[0] = 1'b0; irdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_read(0, 2'(k), d);
      checks++;
      if (d !== 32'h0) begin
        errors++; $display("FAIL rstmid_mem[%0d]: got %h want 0", k, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_wait_states();
    test_invalid_claims();
    test_byte_enables();
    test_burst();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
